// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the single-port RAM bus sequencer.
// Holds the FSM state encoding, the phase counter width and the legal phase-length range.
package mem_ctrl_pkg;

  localparam int CNT_WIDTH = 4;
  localparam int PHASE_MIN = 1;
  localparam int PHASE_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_TURN,
    ST_READ,
    ST_RESP
  } state_t;

  // A phase of N cycles counts down from N-1 to 0.
  function automatic logic [CNT_WIDTH-1:0] phase_load(input int cycles);
    return CNT_WIDTH'(cycles - 1);
  endfunction

endpackage

// File: rtl/mem_controller_phase_counter.sv
// Loadable down-counter that times the WRITE and READ bus phases.
// It saturates at zero and flags zero combinationally.
module phase_counter
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_value,
  input  logic                 i_dec,
  output logic                 o_zero
);

  logic [CNT_WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_controller.sv
// Valid/ready request sequencer driving a single-port RAM with fixed WE/OE phase timing.
// All RAM-side outputs are registered; read data returns on a valid/ready response channel.
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_data_oe,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  if (READ_LATENCY < PHASE_MIN || READ_LATENCY > PHASE_MAX) begin : g_bad_read_latency
    $error("mem_controller: READ_LATENCY outside 1..15");
  end
  if (WRITE_CYCLES < PHASE_MIN || WRITE_CYCLES > PHASE_MAX) begin : g_bad_write_cycles
    $error("mem_controller: WRITE_CYCLES outside 1..15");
  end

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_accept;
  logic                  w_cnt_load;
  logic                  w_cnt_dec;
  logic                  w_cnt_zero;
  logic [CNT_WIDTH-1:0]  w_cnt_load_value;

  assign req_ready = (r_state == ST_IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;

  phase_counter u_phase_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_cnt_load),
    .i_load_value (w_cnt_load_value),
    .i_dec        (w_cnt_dec),
    .o_zero       (w_cnt_zero)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_cnt_load       = 1'b0;
    w_cnt_dec        = 1'b0;
    w_cnt_load_value = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_load = 1'b1;
          if (req_we) begin
            w_next_state     = ST_WRITE;
            w_cnt_load_value = phase_load(WRITE_CYCLES);
          end else begin
            w_next_state     = ST_READ;
            w_cnt_load_value = phase_load(READ_LATENCY);
          end
        end
      end
      ST_WRITE: begin
        if (w_cnt_zero) w_next_state = ST_TURN;
        else            w_cnt_dec    = 1'b1;
      end
      ST_TURN: w_next_state = ST_IDLE;
      ST_READ: begin
        if (w_cnt_zero) w_next_state = ST_RESP;
        else            w_cnt_dec    = 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      mem_we       <= 1'b0;
      mem_oe       <= 1'b0;
      mem_data_oe  <= 1'b0;
      rsp_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      rsp_rdata    <= '0;
    end else begin
      r_state     <= w_next_state;
      mem_we      <= (w_next_state == ST_WRITE);
      mem_data_oe <= (w_next_state == ST_WRITE);
      mem_oe      <= (w_next_state == ST_READ);
      rsp_valid   <= (w_next_state == ST_RESP);
      if (w_accept) begin
        mem_addr <= req_addr;
        if (req_we) mem_data_out <= req_wdata;
      end
      if ((r_state == ST_READ) && w_cnt_zero) rsp_rdata <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench: a transaction-timeline model checks the default build every cycle,
// directed literal checks pin the model, and a second build checks odd phase lengths.
module tb_mem_controller;

  localparam int WC = 2;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0, bus_val = '0;
  logic       req_ready, rsp_valid, mem_we, mem_oe, mem_data_oe;
  logic [7:0] rsp_rdata, mem_addr, mem_data_out;

  logic       b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b1;
  logic [7:0] b_req_addr = '0, b_req_wdata = '0, b_bus = '0;
  logic       b_req_ready, b_rsp_valid, b_mem_we, b_mem_oe, b_mem_data_oe;
  logic [7:0] b_rsp_rdata, b_mem_addr, b_mem_data_out;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_controller dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_data_oe(mem_data_oe), .mem_data_in(bus_val)
  );

  mem_controller #(.READ_LATENCY(1), .WRITE_CYCLES(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .mem_we(b_mem_we), .mem_oe(b_mem_oe), .mem_addr(b_mem_addr),
    .mem_data_out(b_mem_data_out), .mem_data_oe(b_mem_data_oe), .mem_data_in(b_bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: one outstanding transaction, tracked as cycles elapsed since its accept edge.
  typedef enum {OP_NONE, OP_WR, OP_RD, OP_RSP} op_t;
  op_t        m_op = OP_NONE;
  int         m_k = 0;
  logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_op = OP_NONE; m_k = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      case (m_op)
        OP_NONE: if (req_valid) begin
          m_op = req_we ? OP_WR : OP_RD;
          m_k = 1;
          m_addr = req_addr;
          if (req_we) m_wdata = req_wdata;
        end
        OP_WR: if (m_k == WC + 1) m_op = OP_NONE; else m_k++;
        OP_RD: if (m_k == RL) begin m_rdata = bus_val; m_op = OP_RSP; end else m_k++;
        OP_RSP: if (rsp_ready) m_op = OP_NONE;
        default: m_op = OP_NONE;
      endcase
    end
  end

  logic p_oe = 1'b0, p_doe = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",    req_ready,    (m_op == OP_NONE) && rst_n);
      check("mem_we",       mem_we,       (m_op == OP_WR) && (m_k <= WC));
      check("mem_data_oe",  mem_data_oe,  (m_op == OP_WR) && (m_k <= WC));
      check("mem_oe",       mem_oe,       m_op == OP_RD);
      check("rsp_valid",    rsp_valid,    m_op == OP_RSP);
      check("mem_addr",     mem_addr,     m_addr);
      check("mem_data_out", mem_data_out, m_wdata);
      check("rsp_rdata",    rsp_rdata,    m_rdata);
      check("inv_we_oe",    mem_we && mem_oe, 0);
      check("inv_doe_oe",   mem_data_oe && mem_oe, 0);
      check("gap_oe_to_doe", p_oe && mem_data_oe, 0);
      check("gap_doe_to_oe", p_doe && mem_oe, 0);
      check("b_inv_we_oe",  b_mem_we && b_mem_oe, 0);
      p_oe  = mem_oe;
      p_doe = mem_data_oe;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Called 2 ns after an edge; returns 2 ns after the accepting edge.
  task automatic issue_req(input logic we, input logic [7:0] addr, input logic [7:0] data,
                           output int acc_cyc);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        tick(); acc_cyc = cyc; req_valid = 1'b0; return;
      end
      tick();
    end
    check("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic b_issue(input logic we, input logic [7:0] addr, input logic [7:0] data);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = data;
    for (int i = 0; i < 40; i++) begin
      if (b_req_ready) begin
        tick(); b_req_valid = 1'b0; return;
      end
      tick();
    end
    check("b_accept_timeout", 0, 1);
    b_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3;
    logic [3:0] we_h, rdy_h, oe_h, rv_h;
    int cnt;
    bit seen;

    #1 rst_n = 1'b0;
    #2 chk_en = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Single write: WE for 2 cycles, turnaround, ready again in the 4th cycle.
    issue_req(1'b1, 8'h3C, 8'hA5, a0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we_h[3-i] = mem_we; rdy_h[3-i] = req_ready; oe_h[3-i] = mem_oe;
      if (i == 0) begin
        check("wr_addr", mem_addr, 8'h3C);
        check("wr_data", mem_data_out, 8'hA5);
      end
    end
    check("wr_we_pattern", we_h, 4'b1100);
    check("wr_ready_pattern", rdy_h, 4'b0001);
    check("wr_oe_pattern", oe_h, 4'b0000);
    tick();

    // Single read with immediate consumer.
    rsp_ready = 1'b1; bus_val = 8'hA5;
    issue_req(1'b0, 8'h3C, 8'h00, a0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      oe_h[3-i] = mem_oe; rv_h[3-i] = rsp_valid; rdy_h[3-i] = req_ready;
      if (i == 2) check("rd_rdata", rsp_rdata, 8'hA5);
    end
    check("rd_oe_pattern", oe_h, 4'b1100);
    check("rd_rv_pattern", rv_h, 4'b0010);
    check("rd_ready_pattern", rdy_h, 4'b0001);
    tick();

    // Read with stalled consumer; bus changes and a new request waits.
    rsp_ready = 1'b0; bus_val = 8'hA5;
    issue_req(1'b0, 8'h3C, 8'h00, a0);
    tick(); tick();
    bus_val = 8'hFF;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h55; req_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rdata", rsp_rdata, 8'hA5);
      check("stall_ready", req_ready, 0);
    end
    tick();
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    check("stall_no_accept_addr", mem_addr, 8'h3C);
    check("stall_released_ready", req_ready, 1);

    // Back-to-back mixed traffic.
    bus_val = 8'h11;
    issue_req(1'b1, 8'h10, 8'h11, a1);
    issue_req(1'b0, 8'h10, 8'h00, a2);
    issue_req(1'b1, 8'h20, 8'h22, a3);
    check("spacing_wr_to_rd", a2 - a1, 4);
    check("spacing_rd_to_wr", a3 - a2, 4);
    repeat (5) tick();

    // Reset asserted during the 2nd WRITE cycle.
    issue_req(1'b1, 8'h77, 8'h99, a0);
    tick();
    check("mid_we_before_rst", mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("async_we_drop", mem_we, 0);
    check("async_doe_drop", mem_data_oe, 0);
    check("async_ready_low", req_ready, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_we", mem_we, 0);
    tick();

    // READ_LATENCY=1 / WRITE_CYCLES=5 build.
    b_issue(1'b1, 8'h42, 8'h5A);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("b_wr_addr", b_mem_addr, 8'h42);
      cnt += int'(b_mem_we);
    end
    check("b_we_cycles", cnt, 5);
    tick();
    b_bus = 8'hC3;
    b_issue(1'b0, 8'h42, 8'h00);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cnt += int'(b_mem_oe);
      if (b_rsp_valid && !seen) begin
        seen = 1'b1;
        check("b_rd_rdata", b_rsp_rdata, 8'hC3);
      end
    end
    check("b_oe_cycles", cnt, 1);
    check("b_rsp_seen", seen, 1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Bus-master sequencer sitting directly upstream of the single-port RAM.
- Accepts read/write requests over a valid/ready interface and drives the RAM's WE, OE, address and shared data bus with fixed phase timing.
- Returns read data over a valid/ready response channel.
- Drives the bidirectional data bus through a separate output, output-enable and input, which are tied to the tristate at the top level.

Parameters:
- DATA_WIDTH, 8, data bus width.
- ADDR_WIDTH, 8, address bus width.
- READ_LATENCY, 2, cycles OE is held before read data is sampled; legal range 1..15.
- WRITE_CYCLES, 2, cycles WE and driven data are held per write; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  consumer accepts the read data.
- rsp_rdata  output  DATA_WIDTH  read data.
- mem_we  output  1  RAM write enable.
- mem_oe  output  1  RAM output enable.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_data_out  output  DATA_WIDTH  value driven onto the data bus.
- mem_data_oe  output  1  1 = controller drives the data bus.
- mem_data_in  input  DATA_WIDTH  data bus sampled value.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - mem_we, mem_oe, mem_data_oe, rsp_valid all 0.
  - mem_addr, mem_data_out, rsp_rdata all 0.
  - Phase counter is 0.
  - req_ready is 0 while rst_n is low.
  - All state, counter and mem_* outputs are registered (Moore); req_ready = (state == IDLE) and rst_n.
- States: IDLE, WRITE, TURN, READ, RESP.
- IDLE:
  - Accept when req_valid && req_ready at a rising edge; latch req_addr into mem_addr, and req_wdata into mem_data_out if writing.
  - On a write, go to WRITE with counter = WRITE_CYCLES-1.
  - On a read, go to READ with counter = READ_LATENCY-1.
  - No accept means stay in IDLE.
- WRITE:
  - mem_we=1, mem_data_oe=1, mem_oe=0.
  - mem_addr and mem_data_out are stable for exactly WRITE_CYCLES cycles.
  - When counter==0, go to TURN; otherwise decrement.
- TURN: exactly one cycle, all of we/oe/data_oe = 0, then IDLE.
- READ:
  - mem_oe=1, mem_we=0, mem_data_oe=0, for exactly READ_LATENCY cycles.
  - At the edge where counter==0, capture mem_data_in into rsp_rdata and go to RESP.
- RESP:
  - rsp_valid=1, we/oe/data_oe = 0.
  - rsp_rdata is held stable until rsp_ready is high at an edge, then rsp_valid=0 and go to IDLE.
  - RESP lasts at least one cycle, which provides read-to-write bus turnaround.
- Timing, with accept at edge E0:
  - Write: WE is high E0..E0+WRITE_CYCLES; req_ready returns after edge E0+WRITE_CYCLES+1.
  - Read: OE is high E0..E0+READ_LATENCY; rsp_valid rises after edge E0+READ_LATENCY.
  - Back-to-back throughput: write = WRITE_CYCLES+2 cycles per request; read = READ_LATENCY+2 cycles minimum.
- Writes produce no response. rsp_ready is ignored outside RESP.
- Invariants, every cycle:
  - mem_we and mem_oe are never both 1.
  - mem_data_oe is never 1 while mem_oe is 1.
  - At least one cycle with both low separates mem_oe falling from mem_data_oe rising, and vice versa.
- Reset mid-operation: outputs drop immediately and asynchronously. An in-flight write may be partial; a pending read response is discarded. After reset release the controller is in IDLE.
- req_* inputs are ignored outside IDLE. The consumer must not change them while req_valid=1 and req_ready=0 (standard valid/ready rule).
- Counter width: 4 bits.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, WRITE, TURN, READ, RESP);
  - the counter width constant (4);
  - parameter-range check constants.
- One natural sub-module, phase_counter:
  - loadable 4-bit down-counter with load, load_value and a zero flag;
  - shared by the WRITE and READ phases.
- The FSM, datapath registers and output decode stay in mem_controller.

Test Plan:
- Reset then single write (addr 0x3C, data 0xA5, defaults) -> mem_we=1, mem_data_oe=1, mem_addr=0x3C, mem_data_out=0xA5 for exactly 2 cycles; then 1 idle turnaround cycle; req_ready=1 on the 4th cycle after accept; mem_oe stays 0 throughout.
- Single read addr 0x3C, bench drives mem_data_in=0xA5 while mem_oe=1 -> mem_oe high 2 cycles; rsp_valid=1 with rsp_rdata=0xA5 in the 3rd cycle; rsp_ready=1 -> rsp_valid=0 and req_ready=1 next cycle.
- Read with rsp_ready held 0 for 5 cycles, mem_data_in changed to 0xFF after sampling -> rsp_rdata stays 0xA5, rsp_valid stays 1, req_ready stays 0, no new accept while req_valid=1.
- Alternating write 0x10/0x11, read 0x10, write 0x20/0x22 back to back -> invariant checker sees no WE/OE overlap and a ≥1-cycle gap between every OE and data_oe transition; request spacing is 4 cycles for writes and ≥4 for reads.
- rst_n pulled low in the 2nd WRITE cycle -> mem_we and mem_data_oe fall before the next clock edge; after release state is IDLE with req_ready=1 and no rsp_valid.
- READ_LATENCY=1 and WRITE_CYCLES=5 build -> OE is high exactly 1 cycle and WE exactly 5 cycles; captured data matches the value on mem_data_in during the OE cycle.
